ht_empty_ptr_storage: RTL and testbench
=======================================

HT_EMPTY_PTR_STORAGE -- requirements
Module: ht_empty_ptr_storage

Interface
REQ-001 SHALL have parameter A_WIDTH, default 10, giving the data-table address width; the pool holds 2**A_WIDTH pointers.
REQ-002 SHALL have port clk_i  in  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port add_empty_ptr_i  in  A_WIDTH  pointer being returned to the pool.
REQ-005 SHALL have port add_empty_ptr_en_i  in  1  qualifies add_empty_ptr_i.
REQ-006 SHALL have port next_empty_ptr_rd_ack_i  in  1  consumer takes the presented pointer.
REQ-007 SHALL have port next_empty_ptr_o  out  A_WIDTH  oldest free pointer (FIFO head).
REQ-008 SHALL have port next_empty_ptr_val_o  out  1  next_empty_ptr_o is valid.
REQ-009 SHALL have port empty_ptr_cnt_o  out  A_WIDTH+1  number of free pointers held.
REQ-010 SHALL have port init_done_o  out  1  initial fill complete.
REQ-011 SHALL have port overflow_err_o  out  1  one-cycle pulse: add dropped, pool full or still initialising.
REQ-012 SHALL have port double_free_err_o  out  1  one-cycle pulse: add dropped as a duplicate (see REQ-028).

Function
REQ-013 SHALL implement a 2**A_WIDTH-deep FIFO of pointers with rd/wr indices that wrap modulo 2**A_WIDTH.
REQ-014 SHALL have a two-state FSM: INIT, entered on reset, and READY.
REQ-015 In INIT, SHALL write pointer value k on cycle k (k = 0 .. 2**A_WIDTH-1), one per cycle; empty_ptr_cnt_o increments each write.
REQ-016 SHALL move INIT->READY after the last write; init_done_o rises on the cycle READY is entered and stays high until reset.
REQ-017 In INIT, next_empty_ptr_val_o SHALL be 0, rd_ack SHALL be ignored, and an add SHALL be dropped with overflow_err_o pulsed.
REQ-018 In READY, next_empty_ptr_val_o SHALL equal (empty_ptr_cnt_o != 0), and next_empty_ptr_o SHALL equal the FIFO head.
REQ-019 rd_ack with val=1 SHALL pop the head; the next pointer is presented the following cycle; rd_ack with val=0 SHALL be ignored.
REQ-020 An add in READY with count < 2**A_WIDTH SHALL be written at the tail; if the pool was empty, val rises one cycle after the add.
REQ-021 An add with count == 2**A_WIDTH and no same-cycle pop SHALL be dropped with overflow_err_o pulsed.
REQ-022 Simultaneous add and pop SHALL both complete; count is unchanged, including when full, where the pop frees the slot.
REQ-023 Count arithmetic SHALL be A_WIDTH+1 bits wide, with no wrap; count never exceeds 2**A_WIDTH and never goes below 0.
REQ-024 Pointers SHALL leave the pool in FIFO order; after INIT the order is 0,1,2,...

Reset
REQ-025 On rst_i low, SHALL asynchronously clear the indices, count, init_done_o, both error pulses, next_empty_ptr_val_o and next_empty_ptr_o (to 0), and enter INIT.
REQ-026 Reset mid-INIT or mid-READY SHALL discard all pool contents; refill restarts from pointer 0 after release.
REQ-027 FIFO RAM contents SHALL need no reset.

Configuration
REQ-028 With macro HT_EMPTY_PTR_DOUBLE_FREE_CHECK_EN defined, SHALL keep a 2**A_WIDTH-bit "is free" bitmap: set by INIT writes and accepted adds, cleared by pops. An add of a pointer whose bit is already set SHALL be dropped with double_free_err_o pulsed and count unchanged. This check takes precedence over overflow_err_o.
REQ-029 Without the macro, SHALL have no bitmap and double_free_err_o SHALL be tied to 0; duplicates are accepted.

Verification (A_WIDTH=3)
REQ-030 Release reset, then idle -> init_done_o=1 and count=8 after 8 cycles; val=0 throughout INIT.
REQ-031 8 back-to-back acks -> pointers 0..7 in order, then count=0 and val=0; a 9th ack -> no change.
REQ-032 Pool empty, add ptr 5 -> next cycle val=1, ptr=5, count=1.
REQ-033 Count=8, add+ack in the same cycle -> count stays 8 and no overflow_err_o; add alone at count=8 -> overflow_err_o pulses once.
REQ-034 Macro on, ptr 2 free, add 2 -> double_free_err_o pulses and count unchanged; macro off -> accepted and count+1.
REQ-035 Assert reset at INIT cycle 4, then release -> count=0, then refill 0..7 over 8 cycles.

Source files
------------

// File: rtl/ht_empty_ptr_storage.sv
// ht_empty_ptr_storage: FIFO pool of free data-table pointers, self-filled with 0..2**A_WIDTH-1 after reset.
// Optional duplicate-free detection via macro HT_EMPTY_PTR_DOUBLE_FREE_CHECK_EN.
module ht_empty_ptr_storage #(
    parameter int A_WIDTH = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    output logic [A_WIDTH:0]   empty_ptr_cnt_o,
    output logic               init_done_o,
    output logic               overflow_err_o,
    output logic               double_free_err_o
);
    localparam int             DEPTH    = 2**A_WIDTH;
    localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH+1)'(DEPTH);

    typedef enum logic {INIT, READY} state_t;

    state_t             r_state, w_state_nxt;
    logic [A_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_wr_idx, r_rd_idx, w_wr_data;
    logic [A_WIDTH:0]   r_cnt, w_cnt_nxt;
    logic               r_init_done, r_ovf, r_dfree;
    logic               w_ready, w_val, w_pop, w_full, w_dup, w_add, w_ovf, w_wr_en;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_wr_idx == '1)
            w_state_nxt = READY;
    end

    assign w_ready = r_state == READY;
    assign w_val   = w_ready && r_cnt != '0;
    assign w_pop   = w_val && next_empty_ptr_rd_ack_i;
    assign w_full  = r_cnt == FULL_CNT;

`ifdef HT_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
    logic [DEPTH-1:0] r_free;

    assign w_dup = add_empty_ptr_en_i && r_free[add_empty_ptr_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_free <= '0;
        else begin
            if (w_wr_en)
                r_free[w_wr_data] <= 1'b1;
            if (w_pop)
                r_free[r_rd_idx] <= 1'b0;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // a pop at full frees the slot the same-cycle add lands in
    assign w_add     = add_empty_ptr_en_i && w_ready && !w_dup && (!w_full || w_pop);
    assign w_ovf     = add_empty_ptr_en_i && !w_dup && (!w_ready || (w_full && !w_pop));
    assign w_wr_en   = !w_ready || w_add;
    assign w_wr_data = w_ready ? add_empty_ptr_i : r_wr_idx;
    assign w_cnt_nxt = r_cnt + (A_WIDTH+1)'(w_wr_en) - (A_WIDTH+1)'(w_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= INIT;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_ovf       <= 1'b0;
            r_dfree     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_idx    <= w_wr_en ? r_wr_idx + 1'b1 : r_wr_idx;
            r_rd_idx    <= w_pop ? r_rd_idx + 1'b1 : r_rd_idx;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= r_init_done || w_state_nxt == READY;
            r_ovf       <= w_ovf;
            r_dfree     <= w_dup;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en)
            r_mem[r_wr_idx] <= w_wr_data;
    end

    assign next_empty_ptr_o     = w_val ? r_mem[r_rd_idx] : '0;
    assign next_empty_ptr_val_o = w_val;
    assign empty_ptr_cnt_o      = r_cnt;
    assign init_done_o          = r_init_done;
    assign overflow_err_o       = r_ovf;
    assign double_free_err_o    = r_dfree;
endmodule

// File: tb/tb_ht_empty_ptr_storage.sv
// tb_ht_empty_ptr_storage: directed vector table plus reset sequences for ht_empty_ptr_storage at A_WIDTH=3.
module tb_ht_empty_ptr_storage;
`ifdef HT_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
    localparam bit DF = 1'b1;
`else
    localparam bit DF = 1'b0;
`endif

    typedef struct {
        logic       en;
        logic [2:0] ptr;
        logic       ack;
        logic [2:0] e_ptr;
        logic       e_val;
        logic [3:0] e_cnt;
        logic       e_done;
        logic       e_ovf;
        logic       e_df;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [2:0] add_empty_ptr_i = '0;
    logic       add_empty_ptr_en_i = 1'b0;
    logic       next_empty_ptr_rd_ack_i = 1'b0;
    logic [2:0] next_empty_ptr_o;
    logic       next_empty_ptr_val_o;
    logic [3:0] empty_ptr_cnt_o;
    logic       init_done_o, overflow_err_o, double_free_err_o;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    ht_empty_ptr_storage #(.A_WIDTH(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .add_empty_ptr_i(add_empty_ptr_i), .add_empty_ptr_en_i(add_empty_ptr_en_i),
        .next_empty_ptr_rd_ack_i(next_empty_ptr_rd_ack_i),
        .next_empty_ptr_o(next_empty_ptr_o), .next_empty_ptr_val_o(next_empty_ptr_val_o),
        .empty_ptr_cnt_o(empty_ptr_cnt_o), .init_done_o(init_done_o),
        .overflow_err_o(overflow_err_o), .double_free_err_o(double_free_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(logic en, logic [2:0] ptr, logic ack, logic [2:0] e_ptr,
                                logic e_val, logic [3:0] e_cnt, logic e_done, logic e_ovf, logic e_df);
        vec_t v;
        v.en = en; v.ptr = ptr; v.ack = ack; v.e_ptr = e_ptr; v.e_val = e_val;
        v.e_cnt = e_cnt; v.e_done = e_done; v.e_ovf = e_ovf; v.e_df = e_df;
        return v;
    endfunction

    task automatic check(string name, vec_t v);
        n_vec++;
        if ({next_empty_ptr_o, next_empty_ptr_val_o, empty_ptr_cnt_o, init_done_o, overflow_err_o, double_free_err_o}
            !== {v.e_ptr, v.e_val, v.e_cnt, v.e_done, v.e_ovf, v.e_df}) begin
            n_bad++;
            $display("FAIL %s: got ptr=%0d val=%0b cnt=%0d done=%0b ovf=%0b df=%0b, want ptr=%0d val=%0b cnt=%0d done=%0b ovf=%0b df=%0b",
                     name, next_empty_ptr_o, next_empty_ptr_val_o, empty_ptr_cnt_o, init_done_o, overflow_err_o,
                     double_free_err_o, v.e_ptr, v.e_val, v.e_cnt, v.e_done, v.e_ovf, v.e_df);
        end
    endtask

    // called at a negedge; drives, clocks, checks, returns at the next negedge
    task automatic step(string name, vec_t v);
        add_empty_ptr_en_i = v.en;
        add_empty_ptr_i = v.ptr;
        next_empty_ptr_rd_ack_i = v.ack;
        @(posedge clk_i);
        #1;
        check(name, v);
        @(negedge clk_i);
        add_empty_ptr_en_i = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1);
    end

    initial begin
        for (int k = 1; k <= 8; k++)
            tbl.push_back(k == 3 ? mk(1, 7, 1, 0, 0, 4'(k), 0, 1, 0)
                                 : mk(0, 0, 0, 0, k == 8, 4'(k), k == 8, 0, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 1, 3'(k % 8), k < 8, 4'(8 - k), 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 5, 1, 1, 1, 0, 0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(1, 3'(6 + k), 0, 5, 1, 4'(k + 2), 1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 6, 1, DF ? 4'd7 : 4'd8, 1, 0, DF));
        tbl.push_back(mk(1, 6, 0, 6, 1, DF ? 4'd7 : 4'd8, 1, !DF, DF));
        tbl.push_back(mk(0, 0, 0, 6, 1, DF ? 4'd7 : 4'd8, 1, 0, 0));

        repeat (2) @(negedge clk_i);
        check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_i = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        step("pop_before_dup", mk(0, 0, 1, 7, 1, DF ? 4'd6 : 4'd7, 1, 0, 0));
        step("add_free_ptr2", mk(1, 2, 0, 7, 1, DF ? 4'd6 : 4'd8, 1, 0, DF));
        step("err_clear", mk(0, 0, 0, 7, 1, DF ? 4'd6 : 4'd8, 1, 0, 0));

        rst_i = 1'b0;
        #1;
        check("reset_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 1; k <= 4; k++)
            step($sformatf("init_a%0d", k), mk(0, 0, 0, 0, 0, 4'(k), 0, 0, 0));
        #2 rst_i = 1'b0;
        #1;
        check("reset_mid_init", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 1; k <= 8; k++)
            step($sformatf("refill%0d", k), mk(0, 0, 0, 0, k == 8, 4'(k), k == 8, 0, 0));
        for (int k = 1; k <= 8; k++)
            step($sformatf("redrain%0d", k), mk(0, 0, 1, 3'(k % 8), k < 8, 4'(8 - k), 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
